// File: rtl/glm_axi_read_engine.sv
// Splits line-granular read requests into 4 KiB-safe AXI4 INCR bursts, capped in flight; AR valid the cycle after acceptance.
// R beats pass straight through (zero latency); out_ready drives RREADY, ARVALID holds until ARREADY.
module glm_axi_read_engine #(
  parameter int C_M_AXI_GMEM_ADDR_WIDTH = 42,
  parameter int C_M_AXI_GMEM_DATA_WIDTH = 512,
  parameter int C_M_AXI_GMEM_ID_WIDTH   = 1,
  parameter int MAX_BURST_BEATS         = 64,
  parameter int MAX_OUTSTANDING         = 8
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]   req_addr,
  input  logic [31:0]                          req_lines,
  output logic                                 m_axi_gmem_ARVALID,
  input  logic                                 m_axi_gmem_ARREADY,
  output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]   m_axi_gmem_ARADDR,
  output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]     m_axi_gmem_ARID,
  output logic [7:0]                           m_axi_gmem_ARLEN,
  output logic [2:0]                           m_axi_gmem_ARSIZE,
  output logic [1:0]                           m_axi_gmem_ARBURST,
  output logic                                 m_axi_gmem_ARLOCK,
  output logic [3:0]                           m_axi_gmem_ARCACHE,
  output logic [2:0]                           m_axi_gmem_ARPROT,
  output logic [3:0]                           m_axi_gmem_ARQOS,
  output logic [3:0]                           m_axi_gmem_ARREGION,
  input  logic                                 m_axi_gmem_RVALID,
  output logic                                 m_axi_gmem_RREADY,
  input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]   m_axi_gmem_RDATA,
  input  logic                                 m_axi_gmem_RLAST,
  input  logic [C_M_AXI_GMEM_ID_WIDTH-1:0]     m_axi_gmem_RID,
  input  logic [1:0]                           m_axi_gmem_RRESP,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]   out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 err
);

  localparam int         AW        = C_M_AXI_GMEM_ADDR_WIDTH;
  localparam logic [6:0] MAX_BEATS = 7'(MAX_BURST_BEATS);
  localparam logic [7:0] MAX_OUT   = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     remaining_q;
  logic [31:0]     total_q;
  logic [31:0]     rcv_q;
  logic [7:0]      outstanding_q;
  logic [6:0]      beats_q;
  logic            arvalid_q;
  logic            err_q;

  logic            ar_hs;
  logic            r_hs;
  logic            rlast_hs;
  logic [AW-1:0]   addr_d;
  logic [31:0]     remaining_d;
  logic [31:0]     rcv_d;
  logic [7:0]      outstanding_d;
  logic            unused_ok;

  // Largest burst that fits the remaining lines, the burst cap and the current 4 KiB page.
  function automatic logic [6:0] calc_beats(input logic [5:0] line_off, input logic [31:0] rem);
    logic [6:0] b;
    logic [6:0] to_page;
    to_page = 7'd64 - {1'b0, line_off};
    b = (to_page < MAX_BEATS) ? to_page : MAX_BEATS;
    if (rem < {25'd0, b}) b = rem[6:0];
    return b;
  endfunction

  assign ar_hs       = arvalid_q & m_axi_gmem_ARREADY;
  assign r_hs        = m_axi_gmem_RVALID & out_ready;
  assign rlast_hs    = r_hs & m_axi_gmem_RLAST;
  assign addr_d      = addr_q + AW'({beats_q, 6'b0});
  assign remaining_d = remaining_q - {25'd0, beats_q};
  assign rcv_d       = rcv_q + {31'd0, r_hs};

  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs && !rlast_hs)      outstanding_d = outstanding_q + 8'd1;
    else if (!ar_hs && rlast_hs) outstanding_d = outstanding_q - 8'd1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      total_q       <= '0;
      rcv_q         <= '0;
      outstanding_q <= '0;
      beats_q       <= '0;
      arvalid_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rcv_q         <= rcv_d;
      if (r_hs && (m_axi_gmem_RRESP != 2'b00)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= {req_addr[AW-1:6], 6'b0};
            remaining_q <= req_lines;
            total_q     <= req_lines;
            rcv_q       <= '0;
            err_q       <= 1'b0;
            beats_q     <= calc_beats(req_addr[11:6], req_lines);
            if (req_lines == 32'd0) begin
              state_q <= DRAIN;
            end else begin
              state_q   <= ISSUE;
              arvalid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // ARVALID mirrors the registered outstanding count, so a freed slot shows up one cycle later.
          if (ar_hs) begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beats_q     <= calc_beats(addr_d[11:6], remaining_d);
            if (remaining_d == 32'd0) begin
              state_q   <= DRAIN;
              arvalid_q <= 1'b0;
            end else begin
              arvalid_q <= (outstanding_d < MAX_OUT);
            end
          end else if (!arvalid_q) begin
            arvalid_q <= (outstanding_d < MAX_OUT);
          end
        end
        DRAIN: begin
          if (rcv_d == total_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready           = (state_q == IDLE) && !ap_rst;
  assign busy                = (state_q != IDLE);
  assign err                 = err_q;

  assign m_axi_gmem_ARVALID  = arvalid_q;
  assign m_axi_gmem_ARADDR   = addr_q;
  assign m_axi_gmem_ARLEN    = 8'(beats_q) - 8'd1;
  assign m_axi_gmem_ARID     = '0;
  assign m_axi_gmem_ARSIZE   = 3'b110;
  assign m_axi_gmem_ARBURST  = 2'b01;
  assign m_axi_gmem_ARLOCK   = 1'b0;
  assign m_axi_gmem_ARCACHE  = 4'b0011;
  assign m_axi_gmem_ARPROT   = 3'b000;
  assign m_axi_gmem_ARQOS    = 4'b0000;
  assign m_axi_gmem_ARREGION = 4'b0000;

  assign out_valid           = m_axi_gmem_RVALID;
  assign m_axi_gmem_RREADY   = out_ready;
  assign out_data            = m_axi_gmem_RDATA;
  assign out_last            = m_axi_gmem_RVALID && (rcv_q == total_q - 32'd1);

  // A single ID is used, so RID carries no information; address bits [5:0] are ignored.
  assign unused_ok = &{1'b0, m_axi_gmem_RID, req_addr[5:0]};

endmodule

// File: tb/tb_glm_axi_read_engine.sv
// Randomized bench for glm_axi_read_engine: behavioural AXI slave plus a burst/stream reference model.
module tb_glm_axi_read_engine;

  localparam int AW   = 42;
  localparam int DW   = 512;
  localparam int IW   = 1;
  localparam int MAXB = 64;
  localparam int MAXO = 8;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic           req_valid, req_ready;
  logic [AW-1:0]  req_addr;
  logic [31:0]    req_lines;
  logic           m_axi_gmem_ARVALID, m_axi_gmem_ARREADY;
  logic [AW-1:0]  m_axi_gmem_ARADDR;
  logic [IW-1:0]  m_axi_gmem_ARID;
  logic [7:0]     m_axi_gmem_ARLEN;
  logic [2:0]     m_axi_gmem_ARSIZE;
  logic [1:0]     m_axi_gmem_ARBURST;
  logic           m_axi_gmem_ARLOCK;
  logic [3:0]     m_axi_gmem_ARCACHE;
  logic [2:0]     m_axi_gmem_ARPROT;
  logic [3:0]     m_axi_gmem_ARQOS;
  logic [3:0]     m_axi_gmem_ARREGION;
  logic           m_axi_gmem_RVALID, m_axi_gmem_RREADY;
  logic [DW-1:0]  m_axi_gmem_RDATA;
  logic           m_axi_gmem_RLAST;
  logic [IW-1:0]  m_axi_gmem_RID;
  logic [1:0]     m_axi_gmem_RRESP;
  logic           out_valid, out_ready, out_last, busy, err;
  logic [DW-1:0]  out_data;

  always #5 ap_clk = ~ap_clk;

  glm_axi_read_engine #(
    .C_M_AXI_GMEM_ADDR_WIDTH(AW), .C_M_AXI_GMEM_DATA_WIDTH(DW), .C_M_AXI_GMEM_ID_WIDTH(IW),
    .MAX_BURST_BEATS(MAXB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_lines(req_lines),
    .m_axi_gmem_ARVALID(m_axi_gmem_ARVALID), .m_axi_gmem_ARREADY(m_axi_gmem_ARREADY),
    .m_axi_gmem_ARADDR(m_axi_gmem_ARADDR), .m_axi_gmem_ARID(m_axi_gmem_ARID),
    .m_axi_gmem_ARLEN(m_axi_gmem_ARLEN), .m_axi_gmem_ARSIZE(m_axi_gmem_ARSIZE),
    .m_axi_gmem_ARBURST(m_axi_gmem_ARBURST), .m_axi_gmem_ARLOCK(m_axi_gmem_ARLOCK),
    .m_axi_gmem_ARCACHE(m_axi_gmem_ARCACHE), .m_axi_gmem_ARPROT(m_axi_gmem_ARPROT),
    .m_axi_gmem_ARQOS(m_axi_gmem_ARQOS), .m_axi_gmem_ARREGION(m_axi_gmem_ARREGION),
    .m_axi_gmem_RVALID(m_axi_gmem_RVALID), .m_axi_gmem_RREADY(m_axi_gmem_RREADY),
    .m_axi_gmem_RDATA(m_axi_gmem_RDATA), .m_axi_gmem_RLAST(m_axi_gmem_RLAST),
    .m_axi_gmem_RID(m_axi_gmem_RID), .m_axi_gmem_RRESP(m_axi_gmem_RRESP),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  typedef struct { logic [AW-1:0] a; int n; } burst_t;
  typedef struct { logic [AW-1:0] a; logic last; logic [1:0] resp; } beat_t;

  int total = 0;
  int bad   = 0;

  burst_t        exp_ar[$];
  logic [AW-1:0] exp_out[$];
  beat_t         rq[$];
  int            cnt = 0, n_ar = 0, beat_idx = 0, err_idx = -1;
  bit            idle_m = 1, zero_pend = 0, err_m = 0;
  int            ar_pct = 100, r_pct = 100, o_pct = 100;
  bit            r_en = 1, r_pres = 0;
  bit            want_req = 0, want_rst = 0;
  logic [AW-1:0] w_addr = '0;
  logic [31:0]   w_lines = '0;
  logic [21:0]   salt;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_len;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    return {8{salt, a}};
  endfunction

  // Reference split: walk lines from the aligned base, never past MAXB or a 4096-byte page.
  task automatic plan(input logic [AW-1:0] addr, input int lines);
    longint unsigned a;
    longint unsigned room;
    int rem, b;
    a = 64'(addr);
    a = a - (a % 64);
    exp_ar.delete();
    exp_out.delete();
    for (int i = 0; i < lines; i++) exp_out.push_back(AW'(a + 64'(i) * 64));
    rem = lines;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 64;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (64'(b) > room) b = int'(room);
      exp_ar.push_back('{a: AW'(a), n: b});
      a = (a + 64'(b) * 64) % (64'd1 << AW);
      rem -= b;
    end
  endtask

  task automatic step();
    beat_t bt;
    int    n;
    @(negedge ap_clk);
    ap_rst             = want_rst;
    req_valid          = want_req && !want_rst;
    req_addr           = w_addr;
    req_lines          = w_lines;
    m_axi_gmem_ARREADY = ($urandom_range(99) < ar_pct);
    out_ready          = ($urandom_range(99) < o_pct);
    if (!r_pres && rq.size() > 0 && r_en && ($urandom_range(99) < r_pct)) r_pres = 1;
    if (want_rst) r_pres = 0;
    m_axi_gmem_RVALID = r_pres;
    if (r_pres) begin
      m_axi_gmem_RDATA = line_data(rq[0].a);
      m_axi_gmem_RLAST = rq[0].last;
      m_axi_gmem_RRESP = rq[0].resp;
    end else begin
      m_axi_gmem_RDATA = '0;
      m_axi_gmem_RLAST = 1'b0;
      m_axi_gmem_RRESP = 2'b00;
    end
    #1;
    chk("req_ready", req_ready, idle_m && !ap_rst);
    chk("busy", busy, !idle_m);
    chk("err", err, err_m);
    chk("arvalid", m_axi_gmem_ARVALID, (exp_ar.size() > 0) && (cnt < MAXO));
    chk("rready", m_axi_gmem_RREADY, out_ready);
    chk("out_valid", out_valid, m_axi_gmem_RVALID);
    chk("out_last", out_last, m_axi_gmem_RVALID && (exp_out.size() == 1));
    if (prev_stall) begin
      chk("ar_hold_addr", m_axi_gmem_ARADDR, prev_addr);
      chk("ar_hold_len", m_axi_gmem_ARLEN, prev_len);
    end
    if (m_axi_gmem_ARVALID) begin
      if (exp_ar.size() > 0) begin
        chk("araddr", m_axi_gmem_ARADDR, exp_ar[0].a);
        chk("arlen", m_axi_gmem_ARLEN, exp_ar[0].n - 1);
      end
      chk("arsize", m_axi_gmem_ARSIZE, 3'b110);
      chk("arburst", m_axi_gmem_ARBURST, 2'b01);
      chk("arcache", m_axi_gmem_ARCACHE, 4'b0011);
      chk("ar_zero", {m_axi_gmem_ARLOCK, m_axi_gmem_ARPROT, m_axi_gmem_ARQOS,
                      m_axi_gmem_ARREGION, m_axi_gmem_ARID}, 0);
    end
    if (ap_rst) begin
      exp_ar.delete(); exp_out.delete(); rq.delete();
      cnt = 0; idle_m = 1; zero_pend = 0; err_m = 0; r_pres = 0; prev_stall = 0; want_req = 0;
      return;
    end
    if (zero_pend) begin
      idle_m = 1;
      zero_pend = 0;
    end
    if (m_axi_gmem_ARVALID && m_axi_gmem_ARREADY) begin
      if (exp_ar.size() > 0) void'(exp_ar.pop_front());
      n = int'(m_axi_gmem_ARLEN) + 1;
      for (int k = 0; k < n; k++) begin
        bt.a    = m_axi_gmem_ARADDR + AW'(64 * k);
        bt.last = (k == n - 1);
        bt.resp = (beat_idx == err_idx) ? 2'b10 : 2'b00;
        beat_idx++;
        rq.push_back(bt);
      end
      cnt++;
      n_ar++;
    end
    if (m_axi_gmem_RVALID && out_ready) begin
      bt = rq.pop_front();
      r_pres = 0;
      chk("beat_expected", exp_out.size() > 0, 1);
      if (exp_out.size() > 0) begin
        chk("out_data", out_data, line_data(exp_out[0]));
        void'(exp_out.pop_front());
        if (exp_out.size() == 0) idle_m = 1;
      end
      if (bt.resp != 2'b00) err_m = 1;
      if (bt.last) cnt--;
    end
    if (req_valid && req_ready) begin
      plan(req_addr, int'(req_lines));
      idle_m = 0; err_m = 0; beat_idx = 0; want_req = 0;
      if (req_lines == 0) zero_pend = 1;
    end
    prev_stall = m_axi_gmem_ARVALID && !m_axi_gmem_ARREADY;
    prev_addr  = m_axi_gmem_ARADDR;
    prev_len   = m_axi_gmem_ARLEN;
  endtask

  task automatic do_reset();
    want_rst = 1;
    step();
    want_rst = 0;
  endtask

  task automatic run_req(input logic [AW-1:0] addr, input int lines, input int arp, input int rp,
                         input int op, input int eidx, output int cyc);
    ar_pct = arp; r_pct = rp; o_pct = op; err_idx = eidx;
    w_addr = addr; w_lines = 32'(lines); want_req = 1; cyc = 0;
    do begin
      step();
      cyc++;
    end while ((want_req || !idle_m) && cyc < lines * 30 + 100);
    chk("done_in_budget", idle_m && !want_req, 1);
    if (want_req || !idle_m) do_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0, lines;
    logic [AW-1:0] a;
    ap_rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_lines = '0;
    m_axi_gmem_ARREADY = 1'b0; m_axi_gmem_RVALID = 1'b0; m_axi_gmem_RDATA = '0;
    m_axi_gmem_RLAST = 1'b0; m_axi_gmem_RID = '0; m_axi_gmem_RRESP = 2'b00; out_ready = 1'b0;
    salt = 22'($urandom);
    repeat (3) @(negedge ap_clk);
    do_reset();
    step();

    n0 = n_ar; run_req(42'h1000, 1, 100, 100, 100, -1, c);
    chk("t1_nar", n_ar - n0, 1);
    step();

    n0 = n_ar; run_req(42'h0FC0, 3, 100, 100, 100, -1, c);
    chk("t2_nar", n_ar - n0, 2);

    n0 = n_ar; run_req(42'h0, 200, 100, 100, 100, -1, c);
    chk("t3_nar", n_ar - n0, 4);

    // Outstanding cap: no R data until the limit is hit, then release.
    n0 = n_ar; r_en = 0; ar_pct = 100; r_pct = 100; o_pct = 100; err_idx = -1;
    w_addr = 42'h2_0000; w_lines = 32'd1024; want_req = 1;
    repeat (30) step();
    chk("t4_cap", n_ar - n0, MAXO);
    chk("t4_arvalid_low", m_axi_gmem_ARVALID, 0);
    r_en = 1; c = 0;
    while (!idle_m && c < 5000) begin
      step();
      c++;
    end
    chk("t4_done", idle_m, 1);
    chk("t4_nar", n_ar - n0, 16);
    if (!idle_m) do_reset();

    n0 = n_ar; run_req(42'h3_0F40, 10, 50, 70, 50, 4, c);
    chk("t5_nar", n_ar - n0, 2);
    step();
    chk("t5_err", err, 1);
    repeat (3) step();
    chk("t5_err_sticky", err, 1);

    n0 = n_ar; run_req(42'h5000, 0, 100, 100, 100, -1, c);
    chk("t6_cycles", c, 2);
    chk("t6_nar", n_ar - n0, 0);
    step();
    chk("t6_ready", req_ready, 1);

    ar_pct = 100; r_pct = 100; o_pct = 100; err_idx = -1;
    w_addr = 42'h0; w_lines = 32'd200; want_req = 1;
    repeat (40) step();
    chk("t7_busy_pre", busy, 1);
    want_rst = 1;
    step();
    chk("t7_ready_in_rst", req_ready, 0);
    want_rst = 0;
    step();
    chk("t7_arvalid", m_axi_gmem_ARVALID, 0);
    chk("t7_busy", busy, 0);
    chk("t7_last", out_last, 0);
    chk("t7_ready", req_ready, 1);
    n0 = n_ar; run_req(42'h7040, 130, 80, 80, 80, -1, c);
    chk("t7_nar", n_ar - n0, 3);

    n0 = n_ar; run_req(42'h3FF_FFFF_FF95, 5, 70, 70, 70, -1, c);
    chk("t8_wrap_nar", n_ar - n0, 2);

    for (int i = 0; i < 8; i++) begin
      lines = int'($urandom_range(0, 120));
      a = {10'($urandom), 32'($urandom)};
      run_req(a, lines, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)),
              ($urandom_range(1) == 1) ? int'($urandom_range(0, lines)) : -1, c);
    end
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
